// File: rtl/fp_from_fixed_pkg.sv
// Shared FP definitions for the fixed-to-float converter: class flag indices,
// exponent limits derived from the exponent width, and converter FSM states.
package fp_from_fixed_pkg;

  localparam int unsigned NTYPES    = 6;
  localparam int unsigned ZERO      = 0;
  localparam int unsigned SUBNORMAL = 1;
  localparam int unsigned NORMAL    = 2;
  localparam int unsigned INFINITY  = 3;
  localparam int unsigned QNAN      = 4;
  localparam int unsigned SNAN      = 5;

  function automatic int fp_bias(input int unsigned nexp);
    return (1 << (nexp - 1)) - 1;
  endfunction

  function automatic int fp_emax(input int unsigned nexp);
    return fp_bias(nexp);
  endfunction

  function automatic int fp_emin(input int unsigned nexp);
    return 1 - fp_bias(nexp);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_DENORM,
    S_ROUND,
    S_DONE
  } state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even on a normalised significand, then pack {sign, exp, sig}
// and classify the result. Purely combinational.
module fp_round_pack
  import fp_from_fixed_pkg::*;
#(
  parameter int unsigned NEXP = 5,
  parameter int unsigned NSIG = 10,
  parameter int unsigned EW   = 8
) (
  input  logic                 sign,
  input  logic signed [EW-1:0] exp,
  input  logic [NSIG:0]        sig,
  input  logic                 guard,
  input  logic                 sticky,
  output logic [NEXP+NSIG:0]   data_c,
  output logic [NTYPES-1:0]    flags_c,
  output logic                 inexact_c
);

  localparam int BIAS = fp_bias(NEXP);
  localparam logic signed [EW-1:0] EMAX_W = EW'(fp_emax(NEXP));

  logic                 inc;
  logic [NSIG+1:0]      sum;
  logic [NSIG:0]        sig_r;
  logic signed [EW-1:0] exp_r;

  always_comb begin
    inc       = guard & (sticky | sig[0]);
    sum       = {1'b0, sig} + (NSIG+2)'(inc);
    sig_r     = sum[NSIG:0];
    exp_r     = exp;
    data_c    = '0;
    flags_c   = '0;
    inexact_c = guard | sticky;
    // carry out of the significand renormalises to 1.0 at the next exponent
    if (sum[NSIG+1]) begin
      sig_r = {1'b1, {NSIG{1'b0}}};
      exp_r = exp + EW'(1);
    end
    if (exp_r > EMAX_W) begin
      data_c            = {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      flags_c[INFINITY] = 1'b1;
    end else if (!sig_r[NSIG]) begin
      data_c = {sign, {NEXP{1'b0}}, sig_r[NSIG-1:0]};
      if (sig_r == '0) flags_c[ZERO] = 1'b1;
      else             flags_c[SUBNORMAL] = 1'b1;
    end else begin
      data_c          = {sign, NEXP'(exp_r + EW'(BIAS)), sig_r[NSIG-1:0]};
      flags_c[NORMAL] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_from_fixed.sv
// Signed fixed-point to floating-point converter: iterative one-bit-per-cycle
// normalise/denormalise, then a single round-and-pack cycle. One op in flight.
module fp_from_fixed
  import fp_from_fixed_pkg::*;
#(
  parameter int unsigned NEXP = 5,
  parameter int unsigned NSIG = 10,
  parameter int unsigned NINT = 16,
  parameter int unsigned FRAC = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NINT-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     out_data,
  output logic [NTYPES-1:0]      out_flags,
  output logic                   out_inexact
);

  localparam int unsigned EW = $clog2(NINT + FRAC + (1 << NEXP)) + 2;
  localparam logic signed [EW-1:0] EMIN_W   = EW'(fp_emin(NEXP));
  localparam logic signed [EW-1:0] EXP_INIT = EW'(int'(NINT) - 1 - int'(FRAC));

  state_t               state, state_n;
  logic [NINT-1:0]      mag, mag_n;
  logic signed [EW-1:0] exp, exp_n;
  logic                 sign, sign_n;
  logic                 sticky, sticky_n;
  logic [NEXP+NSIG:0]   out_data_n;
  logic [NTYPES-1:0]    out_flags_n;
  logic                 out_inexact_n;

  logic [NINT+NSIG+1:0] ext;
  logic [NEXP+NSIG:0]   rp_data_c;
  logic [NTYPES-1:0]    rp_flags_c;
  logic                 rp_inexact_c;

  // magnitude padded with zeros so short input words still yield sig/guard
  assign ext = {mag, {(NSIG+2){1'b0}}};

  fp_round_pack #(
    .NEXP (NEXP),
    .NSIG (NSIG),
    .EW   (EW)
  ) u_round_pack (
    .sign      (sign),
    .exp       (exp),
    .sig       (ext[NINT+NSIG+1:NINT+1]),
    .guard     (ext[NINT]),
    .sticky    (sticky | (|ext[NINT-1:0])),
    .data_c    (rp_data_c),
    .flags_c   (rp_flags_c),
    .inexact_c (rp_inexact_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      mag         <= '0;
      exp         <= '0;
      sign        <= 1'b0;
      sticky      <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_flags   <= '0;
      out_inexact <= 1'b0;
    end else begin
      state       <= state_n;
      mag         <= mag_n;
      exp         <= exp_n;
      sign        <= sign_n;
      sticky      <= sticky_n;
      in_ready    <= (state_n == S_IDLE);
      out_valid   <= (state_n == S_DONE);
      out_data    <= out_data_n;
      out_flags   <= out_flags_n;
      out_inexact <= out_inexact_n;
    end
  end

  always_comb begin
    state_n       = state;
    mag_n         = mag;
    exp_n         = exp;
    sign_n        = sign;
    sticky_n      = sticky;
    out_data_n    = out_data;
    out_flags_n   = out_flags;
    out_inexact_n = out_inexact;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          sign_n   = in_data[NINT-1];
          mag_n    = in_data[NINT-1] ? -in_data : in_data;
          sticky_n = 1'b0;
          // zero skips normalisation; EMIN keeps the pack stage on the +0 path
          if (mag_n == '0) begin
            sign_n  = 1'b0;
            exp_n   = EMIN_W;
            state_n = S_ROUND;
          end else begin
            exp_n   = EXP_INIT;
            state_n = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (!mag[NINT-1]) begin
          mag_n = mag << 1;
          exp_n = exp - EW'(1);
        end else begin
          state_n = (exp < EMIN_W) ? S_DENORM : S_ROUND;
        end
      end
      S_DENORM: begin
        mag_n    = mag >> 1;
        sticky_n = sticky | mag[0];
        exp_n    = exp + EW'(1);
        if (exp_n == EMIN_W) state_n = S_ROUND;
      end
      S_ROUND: begin
        out_data_n    = rp_data_c;
        out_flags_n   = rp_flags_c;
        out_inexact_n = rp_inexact_c;
        state_n       = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_from_fixed.sv
// Scoreboard bench for fp_from_fixed across three parameter sets
// (16.0, 32.0 and 16.24 fixed point), with backpressure and mid-op reset.
module tb_fp_from_fixed;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic [5:0]  flags;
    logic        inexact;
    int          lat;
  } exp_t;

  localparam logic [5:0] F_ZERO = 6'h01;
  localparam logic [5:0] F_SUB  = 6'h02;
  localparam logic [5:0] F_NORM = 6'h04;
  localparam logic [5:0] F_INF  = 6'h08;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] in_valid, in_ready, out_valid, out_ready, out_inexact;
  logic [15:0] d0, d2;
  logic [31:0] d1;
  logic [2:0][15:0] out_data;
  logic [2:0][5:0]  out_flags;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int acc_cycle = 0;
  int seen_cycle = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  fp_from_fixed #(.NEXP(5), .NSIG(10), .NINT(16), .FRAC(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(d0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_flags(out_flags[0]), .out_inexact(out_inexact[0]));

  fp_from_fixed #(.NEXP(5), .NSIG(10), .NINT(32), .FRAC(0)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(d1), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_flags(out_flags[1]), .out_inexact(out_inexact[1]));

  fp_from_fixed #(.NEXP(5), .NSIG(10), .NINT(16), .FRAC(24)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(d2), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_flags(out_flags[2]), .out_inexact(out_inexact[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: latency from the first out_valid cycle, fields on handshake
  always @(negedge clk) begin
    if (reset) begin
      seen_cycle = -1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i]) begin
          if (seen_cycle < 0) seen_cycle = cycle;
          if (out_ready[i]) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_output", 32'(i), 32'hFFFF_FFFF);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              chk("inst_id", 32'(i), 32'(e.id));
              chk("out_data", 32'(out_data[i]), 32'(e.data));
              chk("out_flags", 32'(out_flags[i]), 32'(e.flags));
              chk("out_inexact", 32'(out_inexact[i]), 32'(e.inexact));
              chk("latency", 32'(seen_cycle - acc_cycle), 32'(e.lat));
            end
            seen_cycle = -1;
          end
        end
      end
    end
  end

  // Called just after a rising edge with the target instance idle
  task automatic send(input int id, input logic [31:0] din, input logic [15:0] data,
                      input logic [5:0] flags, input logic inex, input int lat);
    exp_t e;
    e.id = id; e.data = data; e.flags = flags; e.inexact = inex; e.lat = lat;
    exp_q.push_back(e);
    d0 = din[15:0]; d1 = din; d2 = din[15:0];
    in_valid[id] = 1'b1;
    @(posedge clk); #1;
    acc_cycle = cycle;
    in_valid[id] = 1'b0;
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
    chk("in_ready_after_done", 32'(in_ready[id]), 32'd1);
  endtask

  task automatic conv(input int id, input logic [31:0] din, input logic [15:0] data,
                      input logic [5:0] flags, input logic inex, input int lat);
    send(id, din, data, flags, inex, lat);
    drain(id);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    in_valid = '0;
    out_ready = '1;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("rst_out_data", 32'(out_data[0]), 32'd0);
    chk("rst_out_flags", 32'(out_flags[0]), 32'd0);
    chk("rst_out_inexact", 32'(out_inexact[0]), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    conv(0, 32'd1,          16'h3C00, F_NORM, 1'b0, 17);
    conv(0, 32'hFFFF_FFFE,  16'hC000, F_NORM, 1'b0, 16);
    conv(0, 32'h0000_8000,  16'hF800, F_NORM, 1'b0, 2);
    conv(0, 32'd2049,       16'h6800, F_NORM, 1'b1, 6);
    conv(0, 32'd2051,       16'h6802, F_NORM, 1'b1, 6);
    conv(0, 32'd2047,       16'h67FF, F_NORM, 1'b0, 7);
    conv(0, 32'd0,          16'h0000, F_ZERO, 1'b0, 1);
    conv(1, 32'd65520,      16'h7C00, F_INF,  1'b1, 18);
    conv(1, 32'd65504,      16'h7BFF, F_NORM, 1'b0, 18);
    conv(1, 32'd0,          16'h0000, F_ZERO, 1'b0, 1);
    conv(2, 32'd1,          16'h0001, F_SUB,  1'b0, 27);

    // Backpressure: result held, input side blocked, new request ignored
    out_ready[0] = 1'b0;
    send(0, 32'd1, 16'h3C00, F_NORM, 1'b0, 17);
    n = 0;
    while (!out_valid[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid[0]), 32'd1);
    d0 = 16'd5;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_out_data", 32'(out_data[0]), 32'h3C00);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    drain(0);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_no_extra_valid", 32'(out_valid[0]), 32'd0);

    // Reset while normalising abandons the operation
    d0 = 16'd1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_in_ready", 32'(in_ready[0]), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    conv(0, 32'hFFFF_FFFE, 16'hC000, F_NORM, 1'b0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
